alu_arbiter: RTL and testbench

- Shares one 8-bit ALU instance among NUM_REQ requesters (decode/issue, address gen, branch compare, debug).
- Round-robin arbitration, latches the winner's opcode/operands, drives the ALU, registers result and condition bit, and returns a one-cycle response pulse to the owner.
- Sits between requester logic and the single ALU in the datapath.

---
 rtl/alu_arb_pkg.sv | 27 ++
 rtl/rr_pick.sv | 39 +++
 rtl/alu_arbiter.sv | 165 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and opcode encodings for the ALU arbiter and the blocks that
// talk to the shared 8-bit ALU.
package alu_arb_pkg;

  localparam int unsigned OP_BITS = 3;

  localparam logic [OP_BITS-1:0] OP_AND = 3'b000;
  localparam logic [OP_BITS-1:0] OP_ADD = 3'b001;
  localparam logic [OP_BITS-1:0] OP_SLL = 3'b010;
  localparam logic [OP_BITS-1:0] OP_SRL = 3'b011;
  localparam logic [OP_BITS-1:0] OP_SUB = 3'b100;
  localparam logic [OP_BITS-1:0] OP_SLT = 3'b101;
  localparam logic [OP_BITS-1:0] OP_ABS = 3'b110;
  localparam logic [OP_BITS-1:0] OP_SEQ = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Compare ops report through the condition bit only; result is forced to 0.
  function automatic logic is_cmp(input logic [OP_BITS-1:0] op);
    return (op == OP_SLT) || (op == OP_SEQ);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping around. Produces a one-hot grant and the winner index.
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  int unsigned pos;
  logic [W-1:0] cand;
  logic         found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = 0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = 32'(ptr_i) + i;
      if (pos >= N) begin
        pos = pos - N;
      end
      cand = W'(pos);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// Define ALU_ARB_PIPE_EN to let the RESP cycle also arbitrate (1 op / 2 cycles).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned OP_W    = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*OP_W-1:0]   req_opcode_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_rs_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_rt_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_result_o,
  output logic                      rsp_zero_o,
  output logic                      busy_o,
  output logic [OP_W-1:0]           alu_opcode_o,
  output logic [DATA_W-1:0]         alu_rs_o,
  output logic [DATA_W-1:0]         alu_rt_o,
  input  logic [DATA_W-1:0]         alu_result_i,
  input  logic                      alu_zero_i
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e          state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  owner_q, owner_d;
  logic [OP_W-1:0]     opcode_q, opcode_d;
  logic [DATA_W-1:0]   rs_q, rs_d;
  logic [DATA_W-1:0]   rt_q, rt_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                zero_q, zero_d;
  logic                busy_q, busy_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;

  logic [NUM_REQ-1:0]  arb_req;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_valid;
  logic                arb_en;
  logic                grant_fire;
  logic [OP_W-1:0]     sel_opcode;
  logic [DATA_W-1:0]   sel_rs;
  logic [DATA_W-1:0]   sel_rt;

  // Grant is gated by reset so nothing leaks out while rst_n_i is low.
  always_comb begin
`ifdef ALU_ARB_PIPE_EN
    arb_en  = rst_n_i && ((state_q == IDLE) || (state_q == RESP));
    arb_req = (state_q == RESP) ? (req_i & ~owner_q) : req_i;
`else
    arb_en  = rst_n_i && (state_q == IDLE);
    arb_req = req_i;
`endif
  end

  rr_pick #(
    .N (NUM_REQ),
    .W (PTR_W)
  ) u_rr_pick (
    .req_i   (arb_req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign grant_fire = arb_en && pick_valid;
  assign gnt_o      = grant_fire ? pick_gnt : '0;

  always_comb begin
    sel_opcode = '0;
    sel_rs     = '0;
    sel_rt     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (pick_gnt[k]) begin
        sel_opcode = req_opcode_i[k*OP_W +: OP_W];
        sel_rs     = req_rs_i[k*DATA_W +: DATA_W];
        sel_rt     = req_rt_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    opcode_d    = opcode_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    result_d    = result_q;
    zero_d      = zero_q;
    rsp_valid_d = '0;

    case (state_q)
      IDLE: ;
      EXEC: begin
        // The ALU's condition output is stale for non-compare ops; never forward it.
        if (is_cmp(opcode_q[OP_BITS-1:0])) begin
          result_d = '0;
          zero_d   = alu_zero_i;
        end else begin
          result_d = alu_result_i;
          zero_d   = 1'b0;
        end
        rsp_valid_d = owner_q;
        state_d     = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (grant_fire) begin
      state_d  = EXEC;
      owner_d  = pick_gnt;
      opcode_d = sel_opcode;
      rs_d     = sel_rs;
      rt_d     = sel_rt;
      ptr_d    = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      opcode_q    <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      opcode_q    <= opcode_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = result_q;
  assign rsp_zero_o   = zero_q;
  assign busy_o       = busy_q;

  assign alu_opcode_o = (state_q == EXEC) ? opcode_q : '0;
  assign alu_rs_o     = (state_q == EXEC) ? rs_q     : '0;
  assign alu_rt_o     = (state_q == EXEC) ? rt_q     : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU model.
module tb_alu_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned OW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req;
  logic [N*OW-1:0] req_op;
  logic [N*DW-1:0] req_rs;
  logic [N*DW-1:0] req_rt;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_result;
  logic            rsp_zero;
  logic            busy;
  logic [OW-1:0]   alu_op;
  logic [DW-1:0]   alu_rs;
  logic [DW-1:0]   alu_rt;
  logic [DW-1:0]   alu_res;
  logic            alu_z;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;

  alu_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (DW),
    .OP_W    (OW)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_i        (req),
    .req_opcode_i (req_op),
    .req_rs_i     (req_rs),
    .req_rt_i     (req_rt),
    .gnt_o        (gnt),
    .rsp_valid_o  (rsp_valid),
    .rsp_result_o (rsp_result),
    .rsp_zero_o   (rsp_zero),
    .busy_o       (busy),
    .alu_opcode_o (alu_op),
    .alu_rs_o     (alu_rs),
    .alu_rt_o     (alu_rt),
    .alu_result_i (alu_res),
    .alu_zero_i   (alu_z)
  );

  // ALU model: condition bit stuck high on non-compare ops, junk result on compares.
  always_comb begin
    alu_res = '0;
    alu_z   = 1'b1;
    case (alu_op)
      3'b000: alu_res = alu_rs & alu_rt;
      3'b001: alu_res = alu_rs + alu_rt;
      3'b010: alu_res = alu_rs << alu_rt[2:0];
      3'b011: alu_res = alu_rs >> alu_rt[2:0];
      3'b100: alu_res = alu_rs - alu_rt;
      3'b110: alu_res = alu_rs[7] ? (8'h00 - alu_rs) : alu_rs;
      3'b101: begin alu_res = 8'hA5; alu_z = (alu_rs < alu_rt);  end
      3'b111: begin alu_res = 8'hA5; alu_z = (alu_rs == alu_rt); end
      default: ;
    endcase
  end

  task automatic drive_op(input int k, input logic [2:0] op,
                          input logic [7:0] rs, input logic [7:0] rt);
    req_op[k*OW +: OW] = op;
    req_rs[k*DW +: DW] = rs;
    req_rt[k*DW +: DW] = rt;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) drive_op(k, 3'b001, 8'h01, 8'h01);
    req = 4'b1111;
    @(negedge clk); #1;
    total_cnt++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b expected 0000", gnt); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if ({rsp_result, rsp_zero} !== 9'h000) $display("FAIL reset_result: got %h/%b expected 00/0", rsp_result, rsp_zero); else pass_cnt++;
    total_cnt++; if ({alu_op, alu_rs, alu_rt} !== 19'h0) $display("FAIL reset_alu: got %b/%h/%h expected 0/00/00", alu_op, alu_rs, alu_rt); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    req   = '0;
    #1;
    total_cnt++; if ({gnt, busy} !== 5'b0) $display("FAIL idle_after_reset: got gnt=%b busy=%b expected 0000/0", gnt, busy); else pass_cnt++;
  endtask

  task automatic test_single();
    @(negedge clk);
    drive_op(0, 3'b001, 8'h05, 8'h03);
    req = 4'b0001;
    #1;
    total_cnt++; if (gnt !== 4'b0001) $display("FAIL single_gnt: got %b expected 0001", gnt); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL single_busy_g: got %b expected 0", busy); else pass_cnt++;
    @(negedge clk);
    req = '0;
    #1;
    total_cnt++; if ({gnt, rsp_valid} !== 8'h00) $display("FAIL single_exec_pulses: got gnt=%b rsp=%b expected 0000/0000", gnt, rsp_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL single_busy_exec: got %b expected 1", busy); else pass_cnt++;
    total_cnt++; if ({alu_op, alu_rs, alu_rt} !== {3'b001, 8'h05, 8'h03}) $display("FAIL single_alu_drive: got %b/%h/%h expected 001/05/03", alu_op, alu_rs, alu_rt); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (rsp_valid !== 4'b0001) $display("FAIL single_rsp_valid: got %b expected 0001", rsp_valid); else pass_cnt++;
    total_cnt++; if ({rsp_result, rsp_zero} !== {8'h08, 1'b0}) $display("FAIL single_result: got %h/%b expected 08/0", rsp_result, rsp_zero); else pass_cnt++;
    total_cnt++; if (alu_op !== 3'b000 || alu_rs !== 8'h00) $display("FAIL single_alu_idle: got %b/%h expected 000/00", alu_op, alu_rs); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if ({rsp_valid, busy} !== 5'b0) $display("FAIL single_after: got rsp=%b busy=%b expected 0000/0", rsp_valid, busy); else pass_cnt++;
    total_cnt++; if (rsp_result !== 8'h08) $display("FAIL single_hold: got %h expected 08", rsp_result); else pass_cnt++;
  endtask

  task automatic test_compare();
    @(negedge clk);
    drive_op(2, 3'b111, 8'h2A, 8'h2A);
    req = 4'b0100;
    #1;
    total_cnt++; if (gnt !== 4'b0100) $display("FAIL cmp_seq_gnt: got %b expected 0100", gnt); else pass_cnt++;
    @(negedge clk); req = '0;
    @(negedge clk); #1;
    total_cnt++; if (rsp_valid !== 4'b0100) $display("FAIL cmp_seq_rsp: got %b expected 0100", rsp_valid); else pass_cnt++;
    total_cnt++; if ({rsp_result, rsp_zero} !== {8'h00, 1'b1}) $display("FAIL cmp_seq_result: got %h/%b expected 00/1", rsp_result, rsp_zero); else pass_cnt++;
    @(negedge clk);
    drive_op(2, 3'b001, 8'h01, 8'h01);
    req = 4'b0100;
    #1;
    total_cnt++; if (gnt !== 4'b0100) $display("FAIL cmp_add_gnt: got %b expected 0100", gnt); else pass_cnt++;
    @(negedge clk); req = '0;
    @(negedge clk); #1;
    total_cnt++; if ({rsp_result, rsp_zero} !== {8'h02, 1'b0}) $display("FAIL cmp_add_result: got %h/%b expected 02/0", rsp_result, rsp_zero); else pass_cnt++;
    @(negedge clk);
    drive_op(1, 3'b101, 8'h03, 8'h05);
    req = 4'b0010;
    #1;
    total_cnt++; if (gnt !== 4'b0010) $display("FAIL cmp_slt_gnt: got %b expected 0010", gnt); else pass_cnt++;
    @(negedge clk); req = '0;
    @(negedge clk); #1;
    total_cnt++; if (rsp_valid !== 4'b0010) $display("FAIL cmp_slt_rsp: got %b expected 0010", rsp_valid); else pass_cnt++;
    total_cnt++; if ({rsp_result, rsp_zero} !== {8'h00, 1'b1}) $display("FAIL cmp_slt_result: got %h/%b expected 00/1", rsp_result, rsp_zero); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [7:0] exp_res [4] = '{8'h30, 8'h80, 8'h0F, 8'h0C};
    logic [3:0] exp_g;
    int         wait_cnt;
    apply_reset();
    drive_op(0, 3'b000, 8'hF0, 8'h3C);
    drive_op(1, 3'b001, 8'h7F, 8'h01);
    drive_op(2, 3'b100, 8'h10, 8'h01);
    drive_op(3, 3'b010, 8'h03, 8'h02);
    req = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      exp_g    = 4'b0001 << g;
      wait_cnt = 0;
      #1;
      while (gnt === 4'b0000 && wait_cnt < 8) begin
        @(negedge clk); #1;
        wait_cnt++;
      end
      total_cnt++; if (gnt !== exp_g) $display("FAIL contention_gnt%0d: got %b expected %b", g, gnt, exp_g); else pass_cnt++;
      total_cnt++; if (wait_cnt != 0) $display("FAIL contention_spacing%0d: got %0d extra cycles expected 0", g, wait_cnt); else pass_cnt++;
      @(negedge clk);
      req[g] = 1'b0;
      @(negedge clk); #1;
      total_cnt++; if (rsp_valid !== exp_g) $display("FAIL contention_rsp%0d: got %b expected %b", g, rsp_valid, exp_g); else pass_cnt++;
      total_cnt++; if ({rsp_result, rsp_zero} !== {exp_res[g], 1'b0}) $display("FAIL contention_result%0d: got %h/%b expected %h/0", g, rsp_result, rsp_zero, exp_res[g]); else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g;
    logic [7:0] exp_r;
    int         wait_cnt;
    apply_reset();
    drive_op(0, 3'b001, 8'h11, 8'h22);
    drive_op(2, 3'b011, 8'h80, 8'h03);
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      exp_g    = (i % 2 == 0) ? 4'b0001 : 4'b0100;
      exp_r    = (i % 2 == 0) ? 8'h33 : 8'h10;
      wait_cnt = 0;
      #1;
      while (gnt === 4'b0000 && wait_cnt < 8) begin
        @(negedge clk); #1;
        wait_cnt++;
      end
      total_cnt++; if (gnt !== exp_g || wait_cnt != 0) $display("FAIL fair_gnt%0d: got %b after %0d extra cycles expected %b after 0", i, gnt, wait_cnt, exp_g); else pass_cnt++;
      @(negedge clk);
      @(negedge clk); #1;
      total_cnt++; if (rsp_valid !== exp_g) $display("FAIL fair_rsp%0d: got %b expected %b", i, rsp_valid, exp_g); else pass_cnt++;
      total_cnt++; if (rsp_result !== exp_r) $display("FAIL fair_result%0d: got %h expected %h", i, rsp_result, exp_r); else pass_cnt++;
      @(negedge clk);
    end
    req = '0;
  endtask

`ifdef ALU_ARB_PIPE_EN
  task automatic test_pipe();
    apply_reset();
    drive_op(0, 3'b001, 8'h01, 8'h02);
    drive_op(1, 3'b001, 8'h03, 8'h04);
    req = 4'b0011;
    #1;
    total_cnt++; if (gnt !== 4'b0001) $display("FAIL pipe_gnt0: got %b expected 0001", gnt); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (gnt !== 4'b0000) $display("FAIL pipe_exec0: got %b expected 0000", gnt); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if ({rsp_valid, gnt} !== 8'b0001_0010) $display("FAIL pipe_overlap0: got rsp=%b gnt=%b expected 0001/0010", rsp_valid, gnt); else pass_cnt++;
    total_cnt++; if (rsp_result !== 8'h03) $display("FAIL pipe_result0: got %h expected 03", rsp_result); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if ({rsp_valid, gnt} !== 8'h00) $display("FAIL pipe_exec1: got rsp=%b gnt=%b expected 0000/0000", rsp_valid, gnt); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if ({rsp_valid, gnt} !== 8'b0010_0001) $display("FAIL pipe_overlap1: got rsp=%b gnt=%b expected 0010/0001", rsp_valid, gnt); else pass_cnt++;
    total_cnt++; if (rsp_result !== 8'h07) $display("FAIL pipe_result1: got %h expected 07", rsp_result); else pass_cnt++;
    req = '0;
    repeat (3) @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    drive_op(2, 3'b001, 8'h40, 8'h02);
    req = 4'b0100;
    #1;
    total_cnt++; if (gnt !== 4'b0100) $display("FAIL mid_gnt: got %b expected 0100", gnt); else pass_cnt++;
    @(negedge clk);
    drive_op(0, 3'b001, 8'h01, 8'h01);
    drive_op(3, 3'b001, 8'h02, 8'h02);
    req = 4'b1001;
    #1;
    total_cnt++; if ({busy, alu_op, gnt} !== {1'b1, 3'b001, 4'b0000}) $display("FAIL mid_exec: got busy=%b op=%b gnt=%b expected 1/001/0000", busy, alu_op, gnt); else pass_cnt++;
    #1;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({busy, gnt, rsp_valid} !== 9'h0) $display("FAIL mid_async_ctl: got busy=%b gnt=%b rsp=%b expected 0/0000/0000", busy, gnt, rsp_valid); else pass_cnt++;
    total_cnt++; if ({alu_op, alu_rs, alu_rt} !== 19'h0) $display("FAIL mid_async_alu: got %b/%h/%h expected 0/00/00", alu_op, alu_rs, alu_rt); else pass_cnt++;
    total_cnt++; if ({rsp_result, rsp_zero} !== 9'h0) $display("FAIL mid_async_result: got %h/%b expected 00/0", rsp_result, rsp_zero); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    req   = '0;
    seen  = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (rsp_valid !== 4'b0000) seen++;
    end
    total_cnt++; if (seen != 0) $display("FAIL mid_no_rsp: got %0d rsp cycles expected 0", seen); else pass_cnt++;
    @(negedge clk);
    req = 4'b1001;
    #1;
    total_cnt++; if (gnt !== 4'b0001) $display("FAIL mid_ptr_restart: got %b expected 0001", gnt); else pass_cnt++;
    @(negedge clk); req = '0;
    @(negedge clk); #1;
    total_cnt++; if ({rsp_valid, rsp_result} !== {4'b0001, 8'h02}) $display("FAIL mid_next_rsp: got %b/%h expected 0001/02", rsp_valid, rsp_result); else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req    = '0;
    req_op = '0;
    req_rs = '0;
    req_rt = '0;
    test_reset();
    test_single();
    test_compare();
`ifdef ALU_ARB_PIPE_EN
    test_pipe();
`else
    test_contention();
    test_fairness();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
